// File: rtl/fetch_unit_if.sv
// Narrow program-memory pin bus: one BEAT_W-bit beat per accepted request cycle.
// The fetch unit is the master; program memory answers with instr_valid/instr_data.
interface fetch_unit_if #(
  parameter int PC_W   = 5,
  parameter int BEAT_W = 4
);
  logic              instr_req;
  logic [PC_W-1:0]   instr_addr;
  logic              instr_hi;
  logic              instr_valid;
  logic [BEAT_W-1:0] instr_data;

  modport master (
    output instr_req, instr_addr, instr_hi,
    input  instr_valid, instr_data
  );

  modport slave (
    input  instr_req, instr_addr, instr_hi,
    output instr_valid, instr_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Holds the PC, assembles each instruction from two pin-bus beats (upper first) and strobes exec.
// Latency: exec one cycle after the lower beat; memory backpressures by withholding instr_valid, stall holds EXEC.
module fetch_unit #(
  parameter int PC_W   = 5,
  parameter int BEAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     fb,
  output logic [2:0]       opcode,
  output logic [4:0]       operand,
  output logic             exec,
  input  logic             stall,
  input  logic             bez,
  input  logic             ja,
  input  logic             x8_zero,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc
);

  localparam int INSTR_W = 2 * BEAT_W;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    EXEC     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_HI;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // ja alone is enough; bez needs the x8 zero flag.
  assign taken = ja | (bez & x8_zero);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    fb.instr_req   = 1'b0;
    fb.instr_hi    = 1'b0;
    exec           = 1'b0;
    unique case (state_q)
      FETCH_HI: begin
        fb.instr_req = 1'b1;
        fb.instr_hi  = 1'b1;
        if (fb.instr_valid) begin
          instr_d[INSTR_W-1:BEAT_W] = fb.instr_data;
          state_d                   = FETCH_LO;
        end
      end
      FETCH_LO: begin
        fb.instr_req = 1'b1;
        if (fb.instr_valid) begin
          instr_d[BEAT_W-1:0] = fb.instr_data;
          state_d             = EXEC;
        end
      end
      EXEC: begin
        exec = 1'b1;
        if (!stall) begin
          pc_d    = taken ? branch_target : pc_q + PC_W'(1);
          state_d = FETCH_HI;
        end
      end
      default: state_d = FETCH_HI;
    endcase
  end

  assign fb.instr_addr = pc_q;
  assign pc            = pc_q;
  assign opcode        = instr_q[INSTR_W-1 -: 3];
  assign operand       = instr_q[INSTR_W-4 -: 5];

endmodule
